rx_byte_fifo: RTL and testbench

- Elastic byte buffer between the 8-bit parallel bus receiver and the command parser.
- Absorbs bursts of single-cycle byte strobes arriving from the RPi bus while the parser is busy (hash load, process handshakes).
- Presents bytes to the parser through a first-word-fall-through valid/ready interface.
- Flushes on bus desync and reports overflow and drop statistics for debug LEDs.

---
 rtl/rx_byte_fifo_if.sv | 28 ++
 rtl/rx_byte_fifo.sv | 134 +++++++++++++
 tb/tb_rx_byte_fifo.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/rx_byte_fifo_if.sv
// rtl/rx_byte_fifo_if.sv - byte strobe input and FWFT valid/ready output of the rx byte FIFO
`timescale 1ns/1ps

interface rx_byte_fifo_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   // master: bus receiver + parser side
   modport master (
      output in_data,
      output in_valid,
      output out_ready,
      input  out_data,
      input  out_valid
   );

   // slave: the FIFO itself
   modport slave (
      input  in_data,
      input  in_valid,
      input  out_ready,
      output out_data,
      output out_valid
   );
endinterface

// File: rtl/rx_byte_fifo.sv
// rtl/rx_byte_fifo.sv - elastic FWFT byte buffer between bus receiver and command parser
// Drops bytes when full (counted, sticky overflow); flush discards contents and statistics.
`timescale 1ns/1ps

module rx_byte_fifo #(
   parameter int ADDR_W     = 4,
   parameter int DROP_CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   rx_byte_fifo_if.slave         bus,
   output logic [ADDR_W:0]       level,
   output logic                  full,
   output logic                  overflow,
   output logic [DROP_CNT_W-1:0] drop_count
);

   localparam int              DEPTH      = 1 << ADDR_W;
   localparam logic [ADDR_W:0] FULL_LEVEL = {1'b1, {ADDR_W{1'b0}}};

   logic [7:0]            mem_q [DEPTH];
   logic                  mem_we;

   logic [ADDR_W-1:0]     wr_ptr_q,     wr_ptr_d;
   logic [ADDR_W-1:0]     rd_ptr_q,     rd_ptr_d;
   logic [ADDR_W:0]       level_q,      level_d;
   logic                  full_q,       full_d;
   logic                  out_valid_q,  out_valid_d;
   logic [7:0]            out_data_q,   out_data_d;
   logic                  overflow_q,   overflow_d;
   logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;

   logic rd;
   logic wr_ok;
   logic drop;

   always_comb begin
      rd    = out_valid_q & bus.out_ready;
      // a full FIFO still takes a byte when the head leaves in the same cycle
      wr_ok = bus.in_valid & (~full_q | rd);
      drop  = bus.in_valid & ~wr_ok;
   end

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      level_d      = level_q;
      out_data_d   = out_data_q;
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
      mem_we       = 1'b0;

      if (flush) begin
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         level_d      = '0;
         overflow_d   = 1'b0;
         drop_count_d = '0;
      end else begin
         mem_we = wr_ok;

         if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         end
         if (rd) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
         end

         case ({wr_ok, rd})
            2'b10:   level_d = level_q + (ADDR_W+1)'(1);
            2'b01:   level_d = level_q - (ADDR_W+1)'(1);
            default: level_d = level_q;
         endcase

         if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != '1) begin
               drop_count_d = drop_count_q + DROP_CNT_W'(1);
            end
         end

         // the byte behind the head may be the one being written this very cycle
         if (rd) begin
            if (wr_ok && level_q == (ADDR_W+1)'(1)) begin
               out_data_d = bus.in_data;
            end else begin
               out_data_d = mem_q[rd_ptr_d];
            end
         end else if (wr_ok && level_q == '0) begin
            out_data_d = bus.in_data;
         end
      end

      full_d      = (level_d == FULL_LEVEL);
      out_valid_d = (level_d != '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         full_q       <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         full_q       <= full_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         mem_q[wr_ptr_q] <= bus.in_data;
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign level         = level_q;
   assign full          = full_q;
   assign overflow      = overflow_q;
   assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// tb/tb_rx_byte_fifo.sv - directed scoreboard bench for rx_byte_fifo
`timescale 1ns/1ps

module tb_rx_byte_fifo;

   localparam int ADDR_W     = 4;
   localparam int DROP_CNT_W = 16;
   localparam int DEPTH      = 1 << ADDR_W;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  flush = 1'b0;
   logic [ADDR_W:0]       level;
   logic                  full;
   logic                  overflow;
   logic [DROP_CNT_W-1:0] drop_count;

   int checks   = 0;
   int failures = 0;

   logic [7:0]            exp_q [$];
   logic                  m_ovf;
   logic [DROP_CNT_W-1:0] m_drop;

   rx_byte_fifo_if bus ();

   rx_byte_fifo #(
      .ADDR_W     (ADDR_W),
      .DROP_CNT_W (DROP_CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .bus        (bus),
      .level      (level),
      .full       (full),
      .overflow   (overflow),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // compare against the model at negedge, then advance the model by this cycle's inputs
   task automatic tick();
      logic rd;
      logic acc;
      @(negedge clk);
      check("level", 32'(level), 32'(exp_q.size()));
      check("full", 32'(full), 32'(exp_q.size() == DEPTH));
      check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("drop_count", 32'(drop_count), 32'(m_drop));
      if (exp_q.size() != 0) check("out_data", 32'(bus.out_data), 32'(exp_q[0]));

      if (reset || flush) begin
         exp_q.delete();
         m_ovf  = 1'b0;
         m_drop = '0;
      end else begin
         rd  = (exp_q.size() != 0) && bus.out_ready;
         acc = bus.in_valid && ((exp_q.size() < DEPTH) || rd);
         if (rd) void'(exp_q.pop_front());
         if (acc) begin
            exp_q.push_back(bus.in_data);
         end else if (bus.in_valid) begin
            m_ovf = 1'b1;
            if (m_drop != '1) m_drop = m_drop + 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.out_ready = 1'b0;
      m_ovf         = 1'b0;
      m_drop        = '0;

      reset = 1'b1;
      @(posedge clk);
      #1;
      tick();
      check("reset_out_data", 32'(bus.out_data), 32'h0);
      check("reset_level", 32'(level), 32'h0);
      reset = 1'b0;

      // single byte, held then consumed
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA5;
      tick();
      bus.in_valid = 1'b0;
      check("single_latency", 32'(bus.out_valid), 32'h1);
      repeat (10) tick();
      check("single_hold", 32'(bus.out_data), 32'hA5);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("single_drained", 32'(bus.out_valid), 32'h0);

      // fill, overflow by one, drain
      for (int i = 0; i < DEPTH; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(i);
         tick();
      end
      check("fill_full", 32'(full), 32'h1);
      check("fill_no_ovf", 32'(overflow), 32'h0);
      bus.in_data = 8'hFF;
      tick();
      bus.in_valid = 1'b0;
      check("ovf_sticky", 32'(overflow), 32'h1);
      check("ovf_drop1", 32'(drop_count), 32'h1);
      bus.out_ready = 1'b1;
      repeat (DEPTH + 1) tick();
      bus.out_ready = 1'b0;
      check("drain_empty", 32'(level), 32'h0);

      // full with simultaneous read and write
      for (int i = 0; i < DEPTH; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(i);
         tick();
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.in_data = 8'(8'h10 + i);
         tick();
         check("rw_full_level", 32'(level), 32'(DEPTH));
      end
      bus.in_valid = 1'b0;
      check("rw_full_no_drop", 32'(drop_count), 32'h1);
      repeat (DEPTH + 1) tick();
      bus.out_ready = 1'b0;

      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      check("flush_clears_ovf", 32'(overflow), 32'h0);

      // streaming across pointer wrap, ready high two of every three cycles
      for (int i = 0; i < 40; i++) begin
         bus.in_valid  = 1'b1;
         bus.in_data   = 8'(i);
         bus.out_ready = (i % 3) != 0;
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (24) tick();
      bus.out_ready = 1'b0;
      check("stream_no_drop", 32'(drop_count), 32'h0);
      check("stream_empty", 32'(level), 32'h0);

      // flush with a coincident strobe
      for (int i = 0; i < 7; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(8'h60 + i);
         tick();
      end
      flush       = 1'b1;
      bus.in_data = 8'h77;
      tick();
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      check("flush_level", 32'(level), 32'h0);
      check("flush_valid", 32'(bus.out_valid), 32'h0);
      check("flush_drop", 32'(drop_count), 32'h0);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h42;
      tick();
      bus.in_valid = 1'b0;
      check("after_flush_head", 32'(bus.out_data), 32'h42);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;

      // drop counter saturation
      bus.in_valid = 1'b1;
      for (int i = 0; i < 70000; i++) begin
         bus.in_data = 8'(i);
         tick();
      end
      check("drop_saturated", 32'(drop_count), 32'hFFFF);
      check("sat_overflow", 32'(overflow), 32'h1);

      reset = 1'b1;
      tick();
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      check("mid_reset_level", 32'(level), 32'h0);
      check("mid_reset_full", 32'(full), 32'h0);
      check("mid_reset_valid", 32'(bus.out_valid), 32'h0);
      check("mid_reset_ovf", 32'(overflow), 32'h0);
      check("mid_reset_drop", 32'(drop_count), 32'h0);
      check("mid_reset_data", 32'(bus.out_data), 32'h0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
